// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// One product per WIDTH+2 cycles: one accept cycle, WIDTH RUN cycles and one
// DONE cycle. DONE holds the product under backpressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake; in_ready high only in IDLE
//   a, b                unsigned multiplicand / multiplier (WIDTH bits)
//   out_valid/out_ready product handshake; out_valid high only in DONE
//   p                   unsigned product (2*WIDTH bits), the accumulator
//   busy                high while in RUN

// Parameterised carry-lookahead adder: each carry is the full expanded
// generate/propagate sum-of-products rather than a ripple chain.
module carry_look_ahead #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic             ci;
    logic             pp;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        gen   = a & b;
        prop  = a ^ b;
        carry = '0;
        ci    = 1'b0;
        pp    = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ci = gen[i];
            pp = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                ci = ci | (pp & gen[j]);
                pp = pp & prop[j];
            end
            ci = ci | (pp & cin);
            carry[i+1] = ci;
        end
    end

    assign sum  = prop ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule

module shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   run_sum;
    logic               run_carry;

    // Single adder: upper accumulator half plus multiplicand.
    carry_look_ahead #(.WIDTH(WIDTH)) u_cla (
        .a    (acc_q[ACC_W-1:WIDTH]),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        run_sum   = acc_q[ACC_W-1:WIDTH];
        run_carry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    acc_d   = {WIDTH'(0), b};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (acc_q[0]) begin
                    run_sum   = add_sum;
                    run_carry = add_cout;
                end
                // {carry, sum, acc_lo} >> 1; the carry lands in the MSB.
                acc_d = {run_carry, run_sum, acc_q[WIDTH-1:1]};
                // Counter holds at WIDTH-1 on the last step so it never wraps.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are pure decodes of the state register.
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign p         = acc_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at WIDTH=8.
module tb_shift_add_multiplier;

    localparam int unsigned WIDTH = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    int n_cmp;
    int n_bad;

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair and wait (bounded) for out_valid.
    // lat counts edges from the accepting edge (edge 1); -1 on timeout.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [15:0] rp, output int lat, output int bcnt);
        a = ia;
        b = ib;
        in_valid = 1'b1;
        lat = 0;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
            if (busy) bcnt++;
            if (out_valid) break;
        end
        rp = p;
        if (!out_valid) lat = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] rp;
        int lat, bc;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        #12;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b p=%h, required 1 0 0 0000",
                     in_ready, out_valid, busy, p);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First edge after deassert must accept.
        run_op(8'd4, 8'd5, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'd20 || lat !== 9) begin
            n_bad++;
            $display("FAIL first_accept: p=%0d lat=%0d, required p=20 lat=9", rp, lat);
        end
        step();
    endtask

    task automatic test_basic();
        logic [15:0] rp;
        int lat, bc;
        run_op(8'd13, 8'd11, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'h008F) begin
            n_bad++;
            $display("FAIL basic_product: p=%h, required 008f", rp);
        end
        n_cmp++;
        if (lat !== 9) begin
            n_bad++;
            $display("FAIL basic_latency: edges=%0d, required 9", lat);
        end
        n_cmp++;
        if (bc !== 8) begin
            n_bad++;
            $display("FAIL basic_busy: busy cycles=%0d, required 8", bc);
        end
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_extremes();
        logic [15:0] rp;
        int lat, bc;
        run_op(8'hFF, 8'hFF, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'hFE01 || lat !== 9) begin
            n_bad++;
            $display("FAIL max_operands: p=%h lat=%0d, required fe01 lat=9", rp, lat);
        end
        step();
        run_op(8'h00, 8'hA5, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'h0000 || lat !== 9 || bc !== 8) begin
            n_bad++;
            $display("FAIL zero_multiplicand: p=%h lat=%0d busy=%0d, required 0000 lat=9 busy=8", rp, lat, bc);
        end
        step();
        run_op(8'hA5, 8'h00, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'h0000 || lat !== 9) begin
            n_bad++;
            $display("FAIL zero_multiplier: p=%h lat=%0d, required 0000 lat=9", rp, lat);
        end
        step();
        run_op(8'h80, 8'hFF, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'h7F80) begin
            n_bad++;
            $display("FAIL msb_multiplicand: p=%h, required 7f80", rp);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] rp;
        int lat, bc;
        out_ready = 1'b0;
        run_op(8'd7, 8'd9, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'd63 || lat !== 9) begin
            n_bad++;
            $display("FAIL bp_product: p=%0d lat=%0d, required 63 lat=9", rp, lat);
        end
        // Operands offered during DONE must be ignored.
        a = 8'd1;
        b = 8'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || p !== 16'd63 || in_ready !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b p=%0d in_ready=%b busy=%b, required 1 63 0 0",
                         k, out_valid, p, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] rp;
        int lat, bc;
        int seen;
        a = 8'h55;
        b = 8'h33;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_started: busy=%b, required 1", busy);
        end
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || p !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort_immediate: in_ready=%b busy=%b out_valid=%b p=%h, required 1 0 0 0000",
                     in_ready, busy, out_valid, p);
        end
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_no_output: out_valid cycles=%0d, required 0", seen);
        end
        run_op(8'd2, 8'd3, rp, lat, bc);
        n_cmp++;
        if (rp !== 16'd6 || lat !== 9) begin
            n_bad++;
            $display("FAIL abort_recover: p=%0d lat=%0d, required 6 lat=9", rp, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] exp_p [3];
        logic [15:0] got [3];
        int when [3];
        int idx, nout;
        logic prev_ready;
        va[0] = 8'd3;   vb[0] = 8'd5;   exp_p[0] = 16'd15;
        va[1] = 8'd200; vb[1] = 8'd100; exp_p[1] = 16'h4E20;
        va[2] = 8'd255; vb[2] = 8'd1;   exp_p[2] = 16'd255;
        for (int k = 0; k < 3; k++) begin
            got[k] = '0;
            when[k] = -1;
        end
        idx = 0;
        nout = 0;
        a = va[0];
        b = vb[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            prev_ready = in_ready;
            step();
            if (prev_ready && idx < 3) begin
                idx++;
                if (idx < 3) begin
                    a = va[idx];
                    b = vb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && nout < 3) begin
                got[nout] = p;
                when[nout] = cyc;
                nout++;
            end
            if (nout == 3) break;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (nout !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: products=%0d, required 3", nout);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (got[k] !== exp_p[k]) begin
                n_bad++;
                $display("FAIL b2b_product[%0d]: p=%h, required %h", k, got[k], exp_p[k]);
            end
        end
        n_cmp++;
        if (when[0] !== 8 || when[1] - when[0] !== 10 || when[2] - when[1] !== 10) begin
            n_bad++;
            $display("FAIL b2b_spacing: cycles=%0d,%0d,%0d, required 8,18,28", when[0], when[1], when[2]);
        end
        step();
    endtask

    task automatic test_random();
        logic [15:0] rp;
        logic [7:0]  ra, rb;
        logic [15:0] ref_p;
        int lat, bc;
        out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ref_p = 16'(ra) * 16'(rb);
            run_op(ra, rb, rp, lat, bc);
            n_cmp++;
            if (rp !== ref_p || lat !== 9) begin
                n_bad++;
                $display("FAIL random[%0d]: %0d*%0d p=%0d lat=%0d, required %0d lat=9",
                         k, ra, rb, rp, lat, ref_p);
            end
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
